// File: rtl/mpu_det_engine_if.sv
// Request/response bundle of the sequential determinant engine: row-major flat
// matrix and size in, busy/done handshake and the wrapped and exact determinant out.
interface mpu_det_engine_if #(
    parameter int MAX_N  = 5,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 48,
    parameter int SIZE_W = $clog2(MAX_N + 1)
);
    logic                             start;
    logic [SIZE_W-1:0]                size;
    logic [MAX_N*MAX_N*DATA_W-1:0]    matrix;
    logic                             busy;
    logic                             done;
    logic [DATA_W-1:0]                result;
    logic signed [ACC_W-1:0]          det_full;
    logic                             overflow;
    logic                             size_error;

    modport master (
        output start, size, matrix,
        input  busy, done, result, det_full, overflow, size_error
    );

    modport slave (
        input  start, size, matrix,
        output busy, done, result, det_full, overflow, size_error
    );
endinterface

// File: rtl/mpu_det_engine.sv
// Fraction-free (Bareiss) determinant with row pivoting, one element update per
// cycle; start/busy/done handshake, exact wide result plus legacy wrapped result.
module mpu_det_engine #(
    parameter int MAX_N  = 5,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 48,
    parameter int SIZE_W = $clog2(MAX_N + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    mpu_det_engine_if.slave  bus
);
    localparam int                WIDE_W = 2 * ACC_W;
    localparam logic [SIZE_W-1:0] ONE    = SIZE_W'(1);
    localparam logic [SIZE_W-1:0] N_MAX  = SIZE_W'(MAX_N);

    typedef enum logic [2:0] {IDLE, LOAD, PIVOT, SCAN, ELIM, FINISH} state_t;

    state_t                  state;
    logic [SIZE_W-1:0]       n, k, i, j, last;
    logic signed [ACC_W-1:0] w [MAX_N][MAX_N];
    logic signed [ACC_W-1:0] prev;
    logic                    neg;

    logic signed [ACC_W-1:0]  w_kk, w_ik, w_kj, w_ij, elim_val, fin_det, fin_val;
    logic signed [DATA_W-1:0] fin_low;
    logic signed [WIDE_W-1:0] num;
    logic                     accept, do_swap, fin_go, fin_err, fin_ovf;

    assign last    = n - ONE;
    assign accept  = (state == IDLE) && bus.start;
    assign do_swap = (state == SCAN) && (w_ik != '0);

    // In SCAN, i walks the candidate rows, so w_ik is the candidate pivot.
    always_comb begin
        w_kk     = w[k][k];
        w_ik     = w[i][k];
        w_kj     = w[k][j];
        w_ij     = w[i][j];
        num      = WIDE_W'(w_ij) * WIDE_W'(w_kk) - WIDE_W'(w_ik) * WIDE_W'(w_kj);
        elim_val = ACC_W'(num / WIDE_W'(prev));
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        fin_go  = 1'b0;
        fin_err = 1'b0;
        fin_det = '0;
        case (state)
            LOAD: begin
                if (n == '0 || n > N_MAX) begin
                    fin_go  = 1'b1;
                    fin_err = 1'b1;
                end else if (n == ONE) begin
                    fin_go  = 1'b1;
                    fin_det = w[0][0];
                end
            end
            SCAN:    fin_go = (w_ik == '0) && (i == last);
            ELIM: begin
                if (i == last && j == last && (k + ONE) == last) begin
                    fin_go  = 1'b1;
                    fin_det = elim_val;
                end
            end
            default: fin_go = 1'b0;
        endcase
        fin_val = neg ? -fin_det : fin_det;
        fin_low = fin_val[DATA_W-1:0];
        fin_ovf = (fin_val != ACC_W'(fin_low));
    end

    // Outputs are registered on the edge that enters FINISH, so done and the
    // result appear together and FINISH itself swallows a start in that cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            n              <= '0;
            k              <= '0;
            i              <= '0;
            j              <= '0;
            prev           <= ACC_W'(1);
            neg            <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.result     <= '0;
            bus.det_full   <= '0;
            bus.overflow   <= 1'b0;
            bus.size_error <= 1'b0;
        end else begin
            bus.done <= fin_go;
            if (fin_go) begin
                bus.busy       <= 1'b0;
                bus.det_full   <= fin_val;
                bus.result     <= fin_val[DATA_W-1:0];
                bus.overflow   <= fin_ovf;
                bus.size_error <= fin_err;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n        <= bus.size;
                        prev     <= ACC_W'(1);
                        neg      <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    k     <= '0;
                    state <= fin_go ? FINISH : PIVOT;
                end
                PIVOT: begin
                    i     <= k + ONE;
                    j     <= k + ONE;
                    state <= (w_kk != '0) ? ELIM : SCAN;
                end
                SCAN: begin
                    if (do_swap) begin
                        neg   <= ~neg;
                        i     <= k + ONE;
                        j     <= k + ONE;
                        state <= ELIM;
                    end else if (fin_go) begin
                        state <= FINISH;
                    end else begin
                        i <= i + ONE;
                    end
                end
                ELIM: begin
                    if (j == last) begin
                        if (i == last) begin
                            prev  <= w_kk;
                            k     <= k + ONE;
                            state <= fin_go ? FINISH : PIVOT;
                        end else begin
                            i <= i + ONE;
                            j <= k + ONE;
                        end
                    end else begin
                        j <= j + ONE;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the working array has no reset; every entry is rewritten on accept
    // before anything reads it.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int r = 0; r < MAX_N; r++)
                for (int c = 0; c < MAX_N; c++)
                    w[r][c] <= ACC_W'($signed(bus.matrix[DATA_W*(c+MAX_N*r) +: DATA_W]));
        end else if (do_swap) begin
            // Non-blocking reads see the pre-edge rows, so the swap needs no temporary.
            for (int c = 0; c < MAX_N; c++) begin
                w[k][c] <= w[i][c];
                w[i][c] <= w[k][c];
            end
        end else if (state == ELIM) begin
            w[i][j] <= elim_val;
        end
    end
endmodule
